// File: rtl/daw_pkg.sv
// Shared definitions for the transport/track-store logic.
//   transport_state_t : transport FSM encoding, also exported on the state port
//   SD_ADDR_SHIFT     : channel number -> SD start address shift
//   DEFAULT_POS_W     : default width of the sample position / loop length
package daw_pkg;

    localparam int SD_ADDR_SHIFT = 25;
    localparam int DEFAULT_POS_W = 24;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RECORD = 3'd1,
        PLAY   = 3'd2,
        MIX    = 3'd3,
        DRAIN  = 3'd4
    } transport_state_t;

endpackage

// File: rtl/transport_scheduler_if.sv
// Bus between transport_scheduler (master) and track_store_load (slave).
//   sl_ready                  : engine can take a strobe this cycle (slave -> master)
//   store_req/load_req/mix_req: level requests for the current pass
//   wr/rd/mrd                 : one-cycle write / read / mix-read strobes
//   initial_addr              : SD start address of the selected track
//   position                  : current sample index
interface transport_scheduler_if #(
    parameter int POS_W = 24
);
    logic             sl_ready;
    logic             store_req;
    logic             load_req;
    logic             mix_req;
    logic             wr;
    logic             rd;
    logic             mrd;
    logic [31:0]      initial_addr;
    logic [POS_W-1:0] position;

    modport master (
        input  sl_ready,
        output store_req, load_req, mix_req, wr, rd, mrd, initial_addr, position
    );

    modport slave (
        output sl_ready,
        input  store_req, load_req, mix_req, wr, rd, mrd, initial_addr, position
    );
endinterface

// File: rtl/sample_strobe_gen.sv
// Turns per-sample ticks into one-cycle strobes gated by the engine's ready.
//   clk_in, rst_in : clock, async active-low reset
//   enable         : ticks are accepted only while high (active transport states)
//   tick           : one-cycle sample pulse
//   ready          : engine can take a strobe
//   strobe         : registered one-cycle strobe
//   pending        : a tick is waiting for ready
//   overrun_set    : a tick arrived while one was still waiting (it is dropped)
module sample_strobe_gen (
    input  logic clk_in,
    input  logic rst_in,
    input  logic enable,
    input  logic tick,
    input  logic ready,
    output logic strobe,
    output logic pending,
    output logic overrun_set
);

    logic accept;

    assign accept      = enable && tick;
    // A tick in the same cycle as a ready is not an overrun: the held tick
    // leaves this cycle and the new one takes its place.
    assign overrun_set = accept && pending && !ready;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            strobe  <= 1'b0;
            pending <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so both registers see pre-edge values.
            // A fresh tick with ready high bypasses pending (latency 1).
            strobe  <= (pending || accept) && ready;
            pending <= (pending && !ready) || (accept && (pending || !ready));
        end
    end

endmodule

// File: rtl/transport_scheduler.sv
// Transport sequencer for record / playback / mix passes (65 MHz domain).
//   clk_in, rst_in      : clock, async active-low reset
//   sample_tick         : one-cycle pulse per audio sample (already synchronised)
//   record_toggle       : GUI pulse to start/stop recording
//   record_channel      : target track, latched when recording starts
//   play_en, mix_en     : level enables for playback / mixed playback
//   sl                  : bus to track_store_load (requests, strobes, address, position)
//   loop_len            : loop length in samples, 0 = no take yet
//   state               : transport state (IDLE/RECORD/PLAY/MIX/DRAIN)
//   overrun             : sticky, a tick was dropped during this pass
module transport_scheduler
    import daw_pkg::*;
#(
    parameter int               CHANNELS   = 4,
    parameter int               CH_W       = 5,
    parameter int               POS_W      = DEFAULT_POS_W,
    parameter int               ADDR_SHIFT = SD_ADDR_SHIFT,
    parameter logic [POS_W-1:0] MAX_LEN    = {POS_W{1'b1}}
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  sample_tick,
    input  logic                  record_toggle,
    input  logic [CH_W-1:0]       record_channel,
    input  logic                  play_en,
    input  logic                  mix_en,
    transport_scheduler_if.master sl,
    output logic [POS_W-1:0]      loop_len,
    output logic [2:0]            state,
    output logic                  overrun
);

    transport_state_t cur;
    transport_state_t nxt;
    transport_state_t pass;     // pass that owns any strobe still in flight
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] pos_next;
    logic [31:0]      addr_q;
    logic             store_q;
    logic             load_q;
    logic             mix_q;
    logic             strobe;
    logic             pending;
    logic             overrun_set;
    logic             active;
    logic             rec_go;
    logic             first_take;

    assign active     = (cur == RECORD) || (cur == PLAY) || (cur == MIX);
    assign rec_go     = record_toggle && (int'(record_channel) < CHANNELS);
    assign first_take = (pass == RECORD) && (loop_len == '0);

    sample_strobe_gen u_strobe (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .enable      (active),
        .tick        (sample_tick),
        .ready       (sl.sl_ready),
        .strobe      (strobe),
        .pending     (pending),
        .overrun_set (overrun_set)
    );

    // Position after the strobe currently on the bus. A first take counts up
    // (saturating at the cap); every other pass wraps at the loop end.
    always_comb begin
        // NOTE: default first so no path leaves pos_next unassigned (no latch).
        pos_next = pos;
        if (first_take) begin
            if (pos != MAX_LEN) pos_next = pos + POS_W'(1);
        end else if (pos == loop_len - POS_W'(1)) begin
            pos_next = '0;
        end else begin
            pos_next = pos + POS_W'(1);
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            IDLE: begin
                if (rec_go)                             nxt = RECORD;
                else if (mix_en  && loop_len != '0)     nxt = MIX;
                else if (play_en && loop_len != '0)     nxt = PLAY;
            end
            RECORD: begin
                if (record_toggle ||
                    (strobe && first_take && pos == MAX_LEN - POS_W'(1)))
                    nxt = DRAIN;
            end
            // mix_en is necessarily low on entry to PLAY (mix beats play in
            // IDLE), so any high level seen here is a rising edge.
            PLAY:    if (!play_en || mix_en) nxt = DRAIN;
            MIX:     if (!mix_en)            nxt = DRAIN;
            DRAIN:   if (!pending)           nxt = IDLE;
            default:                         nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cur      <= IDLE;
            pass     <= IDLE;
            pos      <= '0;
            loop_len <= '0;
            addr_q   <= '0;
            store_q  <= 1'b0;
            load_q   <= 1'b0;
            mix_q    <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            cur     <= nxt;
            store_q <= (nxt == RECORD);
            load_q  <= (nxt == PLAY) || (nxt == MIX);
            mix_q   <= (nxt == MIX);

            if (cur == IDLE && nxt != IDLE) begin
                pass    <= nxt;
                pos     <= '0;
                overrun <= 1'b0;
                if (nxt == RECORD) addr_q <= 32'(record_channel) << ADDR_SHIFT;
            end else begin
                if (strobe)      pos     <= pos_next;
                if (overrun_set) overrun <= 1'b1;
            end

            // The take length is fixed only once the last in-flight write
            // has left, so it counts every strobe actually issued.
            if (cur == DRAIN && nxt == IDLE && first_take)
                loop_len <= strobe ? pos_next : pos;
        end
    end

    assign state           = cur;
    assign sl.store_req    = store_q;
    assign sl.load_req     = load_q;
    assign sl.mix_req      = mix_q;
    assign sl.wr           = strobe && (pass == RECORD);
    assign sl.rd           = strobe && (pass == PLAY);
    assign sl.mrd          = strobe && (pass == MIX);
    assign sl.initial_addr = addr_q;
    assign sl.position     = pos;

endmodule
